// File: rtl/xnor_arb.sv
// Two-requester round-robin arbiter feeding a registered bitwise-XNOR unit.
// One transaction in flight at a time: IDLE accepts, RESP holds the result until consumed.
module xnor_arb #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy,
    output logic [15:0]      done_cnt
);

    typedef enum logic {StIdle, StResp} state_t;

    state_t      state;
    logic        last_grant;
    logic        grant0;
    logic        grant1;
    logic [15:0] done_cnt_q;

    // Ties go to the requester that was not granted last; a lone requester always wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && state == StIdle) begin
            if (req0_valid && (!req1_valid || last_grant)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (state == StResp);
    assign done_cnt   = done_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            done_cnt_q <= 16'h0000;
            last_grant <= 1'b1;
        end else begin
            case (state)
                StIdle: begin
                    if (grant0 || grant1) begin
                        rsp_data   <= grant1 ? ~(req1_a ^ req1_b) : ~(req0_a ^ req0_b);
                        rsp_id     <= grant1;
                        last_grant <= grant1;
                        rsp_valid  <= 1'b1;
                        state      <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        done_cnt_q <= done_cnt_q + 16'd1;
                        state      <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
